dcache_responder: RTL and testbench

//   Direct-mapped, write-back, write-allocate cache that services the CPU data-memory port
//   (data_read/data_write/data_mbe -> data_mem_resp/data_mem_rdata).

---
 rtl/dcache_responder_pkg.sv | 11 +
 rtl/dcache_responder_data_array.sv | 19 +
 rtl/dcache_responder.sv | 89 ++++++++
 tb/tb_dcache_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_responder_pkg.sv
// cache_types: shared widths, line type and controller state encoding for the data cache.
package cache_types;
  localparam int SETS = 16;
  localparam int LINE_BYTES = 32;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} dcache_state_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] index_t;
  typedef logic [LINE_BYTES*8-1:0] line_t;
endpackage

// File: rtl/dcache_responder_data_array.sv
// cache_data_array: line storage with async read and byte-enabled synchronous write.
module cache_data_array
  import cache_types::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  index_t                waddr,
  input  logic [LINE_BYTES-1:0] byte_en,
  input  line_t                 wdata,
  input  index_t                raddr,
  output line_t                 rdata
);
  line_t mem [SETS];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < LINE_BYTES; i++)
        if (byte_en[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back write-allocate data cache between the MEM stage and pmem.
module dcache_responder
  import cache_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  input  logic [3:0]  data_mbe,
  output logic [31:0] data_mem_rdata,
  output logic        data_mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output line_t       pmem_wdata,
  input  line_t       pmem_rdata,
  input  logic        pmem_resp
);
  dcache_state_t state, next_state;
  tag_t tags [SETS];
  logic [SETS-1:0] valid, dirty;
  tag_t miss_tag;
  index_t miss_idx;
  tag_t req_tag;
  index_t req_idx;
  logic [2:0] word;
  logic req, hit, miss, store_hit, fill, unused_addr_lsbs;
  line_t line;
  assign req_tag = data_mem_address[31:5+IDX_W];
  assign req_idx = data_mem_address[4+IDX_W:5];
  assign word = data_mem_address[4:2];
  assign unused_addr_lsbs = ^data_mem_address[1:0];
  assign req = data_read | data_write;
  assign hit = valid[req_idx] && tags[req_idx] == req_tag;
  assign miss = state == IDLE && req && !hit;
  assign store_hit = state == IDLE && data_write && hit;
  assign fill = state == ALLOCATE && pmem_resp;
  // A fill writes the whole line; a store hit writes only its enabled lanes.
  cache_data_array u_data (
    .clk    (clk),
    .we     (fill | store_hit),
    .waddr  (fill ? miss_idx : req_idx),
    .byte_en(fill ? {LINE_BYTES{1'b1}} : {28'b0, data_mbe} << {word, 2'b0}),
    .wdata  (fill ? pmem_rdata : {8{data_mem_wdata}}),
    .raddr  (state == IDLE ? req_idx : miss_idx),
    .rdata  (line)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state == IDLE      ? (miss ? (valid[req_idx] && dirty[req_idx] ? WRITEBACK : ALLOCATE) : IDLE)
               : state == WRITEBACK ? (pmem_resp ? ALLOCATE : WRITEBACK)
               :                      (pmem_resp ? IDLE : ALLOCATE);
  end
  // The miss address is latched so a request dropped mid-miss cannot redirect the fill.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= '0;
      dirty <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      if (miss) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
      end
      if (store_hit) dirty[req_idx] <= 1'b1;
      if (state == WRITEBACK && pmem_resp) dirty[miss_idx] <= 1'b0;
      if (fill) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  always_ff @(posedge clk)
    if (fill) tags[miss_idx] <= miss_tag;
  always_comb begin
    data_mem_resp = state == IDLE && req && hit;
    data_mem_rdata = state == IDLE && data_read && !data_write && hit ? line[{word, 5'b0} +: 32] : '0;
    pmem_read = state == ALLOCATE;
    pmem_write = state == WRITEBACK;
    pmem_address = state == WRITEBACK ? {tags[miss_idx], miss_idx, 5'b0}
                 : state == ALLOCATE  ? {miss_tag, miss_idx, 5'b0}
                 :                      32'b0;
    pmem_wdata = state == WRITEBACK ? line : '0;
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed scenario checks of the data cache against a latency-programmable pmem.
module tb_dcache_responder;
  import cache_types::*;
  logic clk = 0, rst = 1, data_read = 0, data_write = 0, pmem_resp = 0;
  logic [31:0] data_mem_address = 0, data_mem_wdata = 0;
  logic [3:0] data_mbe = 0;
  logic [31:0] data_mem_rdata, pmem_address;
  logic data_mem_resp, pmem_read, pmem_write;
  line_t pmem_wdata, pmem_rdata = '0;
  int total = 0, bad = 0, lat = 1, cnt = 0;
  line_t mem [logic [31:0]];

  dcache_responder dut (
    .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata), .data_mbe(data_mbe),
    .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) assert (!(data_read && data_write)) else $error("illegal simultaneous read and write request");

  function automatic line_t mk(int w, logic [31:0] v);
    line_t l = '0;
    l[32*w +: 32] = v;
    return l;
  endfunction

  // Memory model: answers a held request after lat cycles with a one-cycle resp.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      cnt = 0;
      pmem_resp = 0;
    end else if (pmem_resp) pmem_resp = 0;
    else if (pmem_read || pmem_write) begin
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        pmem_resp = 1;
        if (pmem_write) mem[pmem_address] = pmem_wdata;
        else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : '0;
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    data_read = rd;
    data_write = wr;
    data_mem_address = a;
    data_mem_wdata = d;
    data_mbe = m;
  endtask

  task automatic wait_resp(output int n, output int wr_cyc, output logic [31:0] rd_addr);
    n = 0;
    wr_cyc = 0;
    rd_addr = '0;
    #1;
    while (!data_mem_resp) begin
      if (pmem_write) wr_cyc++;
      if (pmem_read) rd_addr = pmem_address;
      if (n >= 200) begin
        n = -1;
        return;
      end
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic finish_req();
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 0;
    #1;
    total++; if (data_mem_resp !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b want 0", data_mem_resp); end
    total++; if (data_mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", data_mem_rdata); end
    total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
    total++; if (pmem_wdata !== '0) begin bad++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int n, w;
    logic [31:0] a;
    mem[32'h1000] = mk(1, 32'hDEADBEEF) | mk(0, 32'h0000_0011);
    lat = 1;
    drive(1, 0, 32'h0000_1004, 0, 0);
    #1;
    total++; if (data_mem_resp !== 1'b0) begin bad++; $display("FAIL fill_miss_resp: got %b want 0", data_mem_resp); end
    @(negedge clk);
    #1;
    total++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin bad++; $display("FAIL fill_pmem_rw: got r=%b w=%b want r=1 w=0", pmem_read, pmem_write); end
    total++; if (pmem_address !== 32'h0000_1000) begin bad++; $display("FAIL fill_addr: got %h want 00001000", pmem_address); end
    wait_resp(n, w, a);
    total++; if (n !== 1) begin bad++; $display("FAIL fill_latency: got %0d want 1", n); end
    total++; if (data_mem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_rdata: got %h want deadbeef", data_mem_rdata); end
    finish_req();
    #1;
    total++; if (data_mem_resp !== 1'b0 || data_mem_rdata !== 32'h0) begin bad++; $display("FAIL idle_outputs: got resp=%b rdata=%h want 0 0", data_mem_resp, data_mem_rdata); end
    @(negedge clk);
  endtask

  task automatic test_write_hit();
    int n, w;
    logic [31:0] a;
    drive(0, 1, 32'h0000_1004, 32'h1234_5678, 4'b0011);
    wait_resp(n, w, a);
    total++; if (n !== 0) begin bad++; $display("FAIL write_hit_latency: got %0d want 0", n); end
    total++; if (data_mem_rdata !== 32'h0) begin bad++; $display("FAIL write_hit_rdata: got %h want 0", data_mem_rdata); end
    finish_req();
    drive(1, 0, 32'h0000_1004, 0, 0);
    wait_resp(n, w, a);
    total++; if (n !== 0) begin bad++; $display("FAIL read_hit_latency: got %0d want 0", n); end
    total++; if (data_mem_rdata !== 32'hDEAD5678) begin bad++; $display("FAIL merged_rdata: got %h want dead5678", data_mem_rdata); end
    finish_req();
  endtask

  task automatic test_dirty_evict();
    int n, w;
    logic [31:0] a;
    line_t l;
    mem[32'h1200] = mk(1, 32'hCAFEF00D);
    lat = 2;
    drive(1, 0, 32'h0000_1204, 0, 0);
    @(negedge clk);
    #1;
    total++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin bad++; $display("FAIL evict_pmem_rw: got r=%b w=%b want r=0 w=1", pmem_read, pmem_write); end
    total++; if (pmem_address !== 32'h0000_1000) begin bad++; $display("FAIL evict_addr: got %h want 00001000", pmem_address); end
    total++; if (pmem_wdata[63:32] !== 32'hDEAD5678) begin bad++; $display("FAIL evict_wdata: got %h want dead5678", pmem_wdata[63:32]); end
    wait_resp(n, w, a);
    total++; if (n !== 5) begin bad++; $display("FAIL evict_latency: got %0d want 5", n); end
    total++; if (a !== 32'h0000_1200) begin bad++; $display("FAIL evict_fill_addr: got %h want 00001200", a); end
    total++; if (data_mem_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL evict_rdata: got %h want cafef00d", data_mem_rdata); end
    finish_req();
    l = mem[32'h1000];
    total++; if (l[63:32] !== 32'hDEAD5678) begin bad++; $display("FAIL evict_mem: got %h want dead5678", l[63:32]); end
  endtask

  task automatic test_clean_conflict();
    int n, w;
    logic [31:0] a;
    lat = 1;
    drive(1, 0, 32'h0000_1004, 0, 0);
    wait_resp(n, w, a);
    total++; if (n !== 2) begin bad++; $display("FAIL clean_latency: got %0d want 2", n); end
    total++; if (w !== 0) begin bad++; $display("FAIL clean_no_writeback: got %0d write cycles want 0", w); end
    total++; if (a !== 32'h0000_1000) begin bad++; $display("FAIL clean_fill_addr: got %h want 00001000", a); end
    total++; if (data_mem_rdata !== 32'hDEAD5678) begin bad++; $display("FAIL clean_rdata: got %h want dead5678", data_mem_rdata); end
    finish_req();
  endtask

  task automatic test_reset_mid_miss();
    int n, w;
    logic [31:0] a;
    mem[32'h2000] = mk(1, 32'h0BADC0DE);
    lat = 20;
    drive(1, 0, 32'h0000_2004, 0, 0);
    @(negedge clk);
    #1;
    total++; if (pmem_read !== 1'b1) begin bad++; $display("FAIL rst_pre_read: got %b want 1", pmem_read); end
    #2 rst = 0;
    #1;
    total++; if (pmem_read !== 1'b0 || pmem_address !== 32'h0) begin bad++; $display("FAIL rst_async_drop: got r=%b addr=%h want 0 0", pmem_read, pmem_address); end
    repeat (2) @(negedge clk);
    lat = 1;
    rst = 1;
    #1;
    total++; if (data_mem_resp !== 1'b0) begin bad++; $display("FAIL rst_valid_cleared: got resp=%b want 0", data_mem_resp); end
    @(negedge clk);
    #1;
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_2000) begin bad++; $display("FAIL rst_remiss: got r=%b addr=%h want 1 00002000", pmem_read, pmem_address); end
    wait_resp(n, w, a);
    total++; if (n !== 1 || data_mem_rdata !== 32'h0BADC0DE) begin bad++; $display("FAIL rst_refill: got n=%0d rdata=%h want 1 0badc0de", n, data_mem_rdata); end
    finish_req();
  endtask

  task automatic test_slow_pmem();
    int n, w, unstable, alloc_bad;
    logic [31:0] a, wb_a;
    line_t wb_d;
    logic seen_wb;
    drive(0, 1, 32'h0000_2008, 32'h55AA_55AA, 4'b1111);
    wait_resp(n, w, a);
    total++; if (n !== 0) begin bad++; $display("FAIL slow_store_hit: got %0d want 0", n); end
    finish_req();
    mem[32'h3000] = mk(2, 32'h1122_3344);
    lat = 10;
    n = 0; unstable = 0; alloc_bad = 0; seen_wb = 0; wb_a = '0; wb_d = '0;
    drive(1, 0, 32'h0000_3008, 0, 0);
    #1;
    while (!data_mem_resp && n < 60) begin
      if (pmem_write) begin
        if (!seen_wb) begin
          wb_a = pmem_address;
          wb_d = pmem_wdata;
          seen_wb = 1;
        end else if (pmem_address !== wb_a || pmem_wdata !== wb_d) unstable++;
      end
      if (pmem_read && pmem_address !== 32'h0000_3000) alloc_bad++;
      @(negedge clk);
      #1;
      n++;
    end
    total++; if (n !== 22) begin bad++; $display("FAIL slow_latency: got %0d want 22", n); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL slow_wb_stable: got %0d changes want 0", unstable); end
    total++; if (alloc_bad !== 0) begin bad++; $display("FAIL slow_fill_addr: got %0d bad cycles want 0", alloc_bad); end
    total++; if (wb_a !== 32'h0000_2000) begin bad++; $display("FAIL slow_wb_addr: got %h want 00002000", wb_a); end
    total++; if (wb_d[95:32] !== 64'h55AA55AA_0BADC0DE) begin bad++; $display("FAIL slow_wb_data: got %h want 55aa55aa0badc0de", wb_d[95:32]); end
    total++; if (data_mem_rdata !== 32'h1122_3344) begin bad++; $display("FAIL slow_rdata: got %h want 11223344", data_mem_rdata); end
    finish_req();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_hit();
    test_dirty_evict();
    test_clean_conflict();
    test_reset_mid_miss();
    test_slow_pmem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
